imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 4, cycles core stays in reset after last write.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  single-cycle request to begin a (re)load.
REQ-007 SHALL have ports s_valid in 1, s_data in 32, s_last in 1: instruction word stream; s_last marks final word.
REQ-008 SHALL have port s_ready  out  1  loader accepts a word this cycle.
REQ-009 SHALL have ports InstrWrite out 1, WriteInst out 32, WriteAdress out 32: write port into imemory.
REQ-010 SHALL have port core_reset  out  1  active-high reset driven to the pipelined core.
REQ-011 SHALL have ports busy out 1, done out 1, err out 1, count out $clog2(DEPTH_WORDS)+1 (words written).

Function
REQ-012 SHALL implement states IDLE, LOAD, FLUSH, RUN, ERROR.
REQ-013 IDLE: core_reset=1, s_ready=0; start=1 -> LOAD next cycle, count cleared to 0.
REQ-014 LOAD: s_ready=1, busy=1, core_reset=1; a beat is accepted when s_valid&&s_ready.
REQ-015 Accepted beat with count<DEPTH_WORDS SHALL produce, on the following cycle only, InstrWrite=1, WriteInst=s_data, WriteAdress=BASE_ADDR+4*count (32-bit, wraps modulo 2^32), and count increments by 1.
REQ-016 Accepted beat with s_last=1 and count<DEPTH_WORDS SHALL be written per REQ-015 and move to FLUSH; s_ready=0 from the next cycle.
REQ-017 Accepted beat with count==DEPTH_WORDS SHALL NOT be written; state -> ERROR.
REQ-018 FLUSH: s_ready=0, core_reset=1, busy=1; a down-counter loaded with FLUSH_CYCLES decrements each cycle; at 0 -> RUN.
REQ-019 RUN: core_reset=0, done=1, busy=0; start=1 -> LOAD with core_reset=1 on the next cycle, count=0.
REQ-020 ERROR: err=1, core_reset=1, s_ready=0; only start=1 leaves it (-> LOAD, err cleared, count=0).
REQ-021 start SHALL be ignored in LOAD and FLUSH.
REQ-022 InstrWrite SHALL be 0 in every cycle not covered by REQ-015; WriteInst/WriteAdress hold last value.
REQ-023 Zero-length load is impossible; an s_last beat is always a real word (DEPTH_WORDS words max incl. last).

Reset
REQ-024 reset=0 SHALL asynchronously force IDLE, count=0, flush counter=0, InstrWrite=0, WriteInst=0, WriteAdress=BASE_ADDR, s_ready=0, busy=0, done=0, err=0, core_reset=1.
REQ-025 reset asserted mid-LOAD SHALL abort the load with no further writes; loaded contents are not guaranteed.
REQ-026 Outputs SHALL be registered; core_reset SHALL be glitch-free (state-decoded register).

Structure
REQ-027 State enum loader_state_t and default BASE_ADDR/FLUSH_CYCLES constants SHALL live in shared package riscv_pkg.
REQ-028 Flush down-counter MAY be sub-module delay_counter; everything else in one module, instantiated between the external host stream and imemory/pipelined in top.

Verification
REQ-029 reset, start, 3 beats 0x00500093/0x00A00113/0x002081B3 (last on 3rd) -> writes at 0x0,0x4,0x8, count=3, core_reset falls exactly 4 cycles after final write cycle, done=1.
REQ-030 s_valid toggling every other cycle, 5 words -> 5 writes only on accept+1 cycles, addresses contiguous, no duplicates.
REQ-031 DEPTH_WORDS=4, 5 beats, last on 5th -> 4 writes, 5th not written, err=1, core_reset=1; start -> err=0, LOAD.
REQ-032 In RUN, start -> core_reset=1 next cycle, reload of 2 words from BASE_ADDR=0x100 writes 0x100,0x104.
REQ-033 reset low during 2nd beat of LOAD -> InstrWrite=0 immediately, IDLE, count=0, core_reset=1; start in LOAD/FLUSH ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: loader state encoding and default loader constants shared across the core
package riscv_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, ERROR} loader_state_t;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;
  localparam int DEFAULT_FLUSH_CYCLES = 4;
endpackage

// File: rtl/delay_counter.sv
// delay_counter: loadable down-counter that flags its final counting cycle
module delay_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] loadValue,
  output logic         expiring
);
  logic [W-1:0] cnt;
  assign expiring = cnt <= W'(1);
  // load on entry, then count down to zero and stay there
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (load) cnt <= loadValue;
    else if (cnt != '0) cnt <= cnt - W'(1);
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams instruction words into imemory while holding the core in reset
module imem_loader
  import riscv_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 256,
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int          FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         s_valid,
  input  logic [31:0]                  s_data,
  input  logic                         s_last,
  output logic                         s_ready,
  output logic                         InstrWrite,
  output logic [31:0]                  WriteInst,
  output logic [31:0]                  WriteAdress,
  output logic                         core_reset,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(DEPTH_WORDS):0] count
);
  localparam int CW = $clog2(DEPTH_WORDS) + 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 2);
  loader_state_t state, nextState;
  logic accept, room, flushDone;
  assign accept = s_valid && s_ready;
  assign room = count < CW'(DEPTH_WORDS);
  delay_counter #(.W(FW)) flushTimer (
    .clk(clk),
    .reset(reset),
    .load(state != FLUSH && nextState == FLUSH),
    .loadValue(FW'(FLUSH_CYCLES)),
    .expiring(flushDone)
  );
  // next-state: start only honoured outside LOAD/FLUSH, overflow beat diverts to ERROR
  always_comb begin
    nextState = state;
    case (state)
      IDLE, RUN, ERROR: nextState = start ? LOAD : state;
      LOAD:             nextState = !accept ? LOAD : !room ? ERROR : s_last ? FLUSH : LOAD;
      FLUSH:            nextState = flushDone ? RUN : FLUSH;
      default:          nextState = IDLE;
    endcase
  end
  // state plus registered outputs decoded from the next state so they change glitch-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      InstrWrite  <= 1'b0;
      WriteInst   <= '0;
      WriteAdress <= BASE_ADDR;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      core_reset  <= 1'b1;
    end else begin
      state      <= nextState;
      s_ready    <= nextState == LOAD;
      busy       <= nextState == LOAD || nextState == FLUSH;
      done       <= nextState == RUN;
      err        <= nextState == ERROR;
      core_reset <= nextState != RUN;
      InstrWrite <= accept && room;
      if (accept && room) begin
        WriteInst   <= s_data;
        WriteAdress <= BASE_ADDR + (32'(count) << 2);
        count       <= count + CW'(1);
      end else if (state != LOAD && nextState == LOAD) begin
        count <= '0;
      end
    end
  end
endmodule
